peripheral_msi_cc561_arb_wb: RTL and testbench



---
 rtl/peripheral_msi_cc561_arb_wb_if.sv | 31 +++
 rtl/peripheral_msi_cc561_arb_wb.sv | 120 ++++++++++++
 tb/tb_peripheral_msi_cc561_arb_wb.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_msi_cc561_arb_wb_if.sv
// Requester/channel bundle for the cc561 source-side arbiter.
//   en         : channel enable (0 blocks new launches)
//   req        : per-requester level request
//   req_data   : requester i word at bits [i*DW +: DW]
//   gnt        : one-hot, one-cycle launch acknowledge
//   adata/aen  : drive the cc561 channel adata/aen inputs
//   busy       : high while the spacing hold is running
//   issued_cnt : wrapping count of launched words
interface peripheral_msi_cc561_arb_wb_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32
);
    logic              en;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic [DW-1:0]     adata;
    logic              aen;
    logic              busy;
    logic [15:0]       issued_cnt;

    modport slave (
        input  en, req, req_data,
        output gnt, adata, aen, busy, issued_cnt
    );

    modport master (
        output en, req, req_data,
        input  gnt, adata, aen, busy, issued_cnt
    );
endinterface

// File: rtl/peripheral_msi_cc561_arb_wb.sv
// Source-domain round-robin scheduler sharing one cc561 toggle-pulse CDC
// channel among N requesters. aen pulses are spaced at least GAP aclk cycles
// apart so the destination synchroniser never misses a toggle.
//   aclk   : source-domain clock
//   arst_n : asynchronous active-low reset
//   bus    : requester side (en/req/req_data/gnt), channel side (adata/aen),
//            status (busy/issued_cnt); all outputs registered
module peripheral_msi_cc561_arb_wb #(
    parameter int unsigned DW  = 32,
    parameter int unsigned N   = 4,
    parameter int unsigned GAP = 4,
    parameter int unsigned CW  = 8
) (
    input  logic                               aclk,
    input  logic                               arst_n,
    peripheral_msi_cc561_arb_wb_if.slave       bus
);
    localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ICW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [DW-1:0]     adata_q, adata_d;
    logic              aen_q, aen_d;
    logic              busy_q, busy_d;
    logic [ICW-1:0]    issued_cnt_q, issued_cnt_d;

    logic              found_c;
    logic [PW-1:0]     win_c;
    logic [PW-1:0]     idx_c;

    // Round-robin search: first requester at or after rr_ptr, modulo N.
    always_comb begin : pick_winner
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx_c = PW'((32'(rr_ptr_q) + i) % N);
            if (!found_c && bus.req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin : next_state
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        adata_d      = adata_q;
        aen_d        = 1'b0;
        issued_cnt_d = issued_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.en && found_c) begin
                    aen_d        = 1'b1;
                    gnt_d[win_c] = 1'b1;
                    adata_d      = bus.req_data[32'(win_c)*DW +: DW];
                    rr_ptr_d     = (32'(win_c) == N - 1) ? '0 : PW'(32'(win_c) + 1);
                    cnt_d        = CW'(GAP - 1);
                    issued_cnt_d = issued_cnt_q + 16'd1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                // en is ignored here so a started spacing window always completes.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == HOLD);
    end

    always_ff @(posedge aclk or negedge arst_n) begin : regs
        if (!arst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            adata_q      <= '0;
            aen_q        <= 1'b0;
            busy_q       <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            adata_q      <= adata_d;
            aen_q        <= aen_d;
            busy_q       <= busy_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.adata      = adata_q;
    assign bus.aen        = aen_q;
    assign bus.busy       = busy_q;
    assign bus.issued_cnt = issued_cnt_q;

    // A pulse always carries exactly one grant, and never more than one.
    a_gnt_aen : assert property (@(posedge aclk) disable iff (!arst_n)
        (aen_q == (|gnt_q)) && $onehot0(gnt_q));

endmodule

// File: tb/tb_peripheral_msi_cc561_arb_wb.sv
// Bench for the cc561 source-side arbiter: two instances (GAP=4 and GAP=6)
// checked every cycle against a reference scheduler expressed in terms of
// "cycles since last launch" and a round-robin pointer.
module tb_peripheral_msi_cc561_arb_wb;
    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 8;
    localparam int unsigned GAP0 = 4;
    localparam int unsigned GAP1 = 6;

    logic aclk = 1'b0;
    logic arst_n;
    always #5 aclk = ~aclk;

    peripheral_msi_cc561_arb_wb_if #(.N(N), .DW(DW)) bus0 ();
    peripheral_msi_cc561_arb_wb_if #(.N(N), .DW(DW)) bus1 ();

    peripheral_msi_cc561_arb_wb #(.DW(DW), .N(N), .GAP(GAP0), .CW(CW)) dut0 (
        .aclk   (aclk),
        .arst_n (arst_n),
        .bus    (bus0.slave)
    );

    peripheral_msi_cc561_arb_wb #(.DW(DW), .N(N), .GAP(GAP1), .CW(CW)) dut1 (
        .aclk   (aclk),
        .arst_n (arst_n),
        .bus    (bus1.slave)
    );

    // Stimulus per instance.
    logic          en_v   [2];
    logic [N-1:0]  req_v  [2];
    logic [DW-1:0] data_v [2][N];

    assign bus0.en  = en_v[0];
    assign bus1.en  = en_v[1];
    assign bus0.req = req_v[0];
    assign bus1.req = req_v[1];
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus0.req_data[i*DW +: DW] = data_v[0][i];
            bus1.req_data[i*DW +: DW] = data_v[1][i];
        end
    end

    // Observed outputs.
    logic [N-1:0]  o_gnt   [2];
    logic [DW-1:0] o_adata [2];
    logic          o_aen   [2];
    logic          o_busy  [2];
    logic [15:0]   o_iss   [2];
    assign o_gnt[0]   = bus0.gnt;        assign o_gnt[1]   = bus1.gnt;
    assign o_adata[0] = bus0.adata;      assign o_adata[1] = bus1.adata;
    assign o_aen[0]   = bus0.aen;        assign o_aen[1]   = bus1.aen;
    assign o_busy[0]  = bus0.busy;       assign o_busy[1]  = bus1.busy;
    assign o_iss[0]   = bus0.issued_cnt; assign o_iss[1]   = bus1.issued_cnt;

    // Reference model state.
    int            cyc;
    int            m_last  [2];
    int            m_rr    [2];
    logic [15:0]   m_iss   [2];
    logic [DW-1:0] m_adata [2];
    logic [N-1:0]  e_gnt   [2];
    logic          e_aen   [2];
    logic          e_busy  [2];

    int tests = 0;
    int fails = 0;

    function automatic int gap_of(int u);
        return (u == 0) ? int'(GAP0) : int'(GAP1);
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_last[u]  = -1000;
            m_rr[u]    = 0;
            m_iss[u]   = '0;
            m_adata[u] = '0;
            e_gnt[u]   = '0;
            e_aen[u]   = 1'b0;
            e_busy[u]  = 1'b0;
        end
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_edge();
        cyc++;
        for (int u = 0; u < 2; u++) begin
            bit hit;
            hit      = 1'b0;
            e_gnt[u] = '0;
            e_aen[u] = 1'b0;
            if ((cyc - m_last[u] >= gap_of(u)) && en_v[u]) begin
                for (int o = 0; o < int'(N); o++) begin
                    int k;
                    k = (m_rr[u] + o) % int'(N);
                    if (!hit && req_v[u][k]) begin
                        hit         = 1'b1;
                        e_gnt[u][k] = 1'b1;
                        e_aen[u]    = 1'b1;
                        m_adata[u]  = data_v[u][k];
                        m_rr[u]     = (k + 1) % int'(N);
                        m_last[u]   = cyc;
                        m_iss[u]    = m_iss[u] + 16'd1;
                    end
                end
            end
            e_busy[u] = (cyc - m_last[u]) < (gap_of(u) - 1);
        end
    endtask

    task automatic chk(string tag, int u, logic [DW-1:0] obs, logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s[dut%0d] cyc=%0d observed=%h expected=%h", tag, u, cyc, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            chk("aen",   u, DW'(o_aen[u]),  DW'(e_aen[u]));
            chk("gnt",   u, DW'(o_gnt[u]),  DW'(e_gnt[u]));
            chk("adata", u, o_adata[u],     m_adata[u]);
            chk("busy",  u, DW'(o_busy[u]), DW'(e_busy[u]));
            chk("issued_cnt", u, DW'(o_iss[u]), DW'(m_iss[u]));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge aclk);
        #1;
        check_all();
    endtask

    // After a grant the winner presents a fresh word (request stays up).
    task automatic renew(int u);
        for (int i = 0; i < int'(N); i++) begin
            if (o_gnt[u][i]) data_v[u][i] = $urandom;
        end
    endtask

    initial begin
        int guard;
        arst_n = 1'b0;
        cyc    = 0;
        for (int u = 0; u < 2; u++) begin
            en_v[u]  = 1'b0;
            req_v[u] = '0;
            for (int i = 0; i < int'(N); i++) data_v[u][i] = '0;
        end
        model_reset();

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        check_all();
        arst_n = 1'b1;
        tick();

        // Single request from requester 2.
        en_v[0]      = 1'b1;
        req_v[0]     = 4'b0100;
        data_v[0][2] = 32'hDEADBEEF;
        tick();
        chk("single_aen",   0, DW'(o_aen[0]), 32'd1);
        chk("single_gnt",   0, DW'(o_gnt[0]), 32'd4);
        chk("single_adata", 0, o_adata[0],    32'hDEADBEEF);
        chk("single_iss",   0, DW'(o_iss[0]), 32'd1);
        req_v[0] = '0;
        repeat (5) tick();

        // All four requesters held high.
        for (int i = 0; i < int'(N); i++) data_v[0][i] = $urandom;
        req_v[0] = 4'b1111;
        repeat (24) begin
            tick();
            renew(0);
        end
        req_v[0] = '0;
        repeat (4) tick();

        // Back-to-back words from requester 1 on the GAP=6 instance.
        en_v[1]      = 1'b1;
        req_v[1]     = 4'b0010;
        data_v[1][1] = $urandom;
        repeat (30) begin
            tick();
            renew(1);
        end
        req_v[1] = '0;
        repeat (6) tick();

        // en low blocks launches; grant resumes from rr_ptr once enabled.
        en_v[0]  = 1'b0;
        req_v[0] = 4'b1111;
        repeat (10) tick();
        en_v[0] = 1'b1;
        tick();
        renew(0);

        // en dropped during HOLD: the window completes, then nothing launches.
        en_v[0] = 1'b0;
        repeat (8) tick();
        en_v[0] = 1'b1;
        repeat (3) begin
            tick();
            renew(0);
        end
        repeat (4) tick();

        // Asynchronous reset two cycles into HOLD.
        guard = 0;
        while (!o_aen[0] && guard < 10) begin
            tick();
            guard++;
        end
        chk("launch_seen", 0, DW'(o_aen[0]), 32'd1);
        repeat (2) tick();
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst_aen",   0, DW'(o_aen[0]),  32'd0);
        chk("rst_gnt",   0, DW'(o_gnt[0]),  32'd0);
        chk("rst_busy",  0, DW'(o_busy[0]), 32'd0);
        chk("rst_adata", 0, o_adata[0],     32'd0);
        chk("rst_iss",   0, DW'(o_iss[0]),  32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        check_all();
        arst_n   = 1'b1;
        req_v[0] = 4'b1000;
        tick();
        chk("post_rst_gnt", 0, DW'(o_gnt[0]), 32'd8);
        req_v[0] = '0;
        repeat (4) tick();

        // Rotation from a freshly reset pointer starts at requester 0.
        req_v[0] = 4'b1111;
        repeat (12) begin
            tick();
            renew(0);
        end
        req_v[0] = '0;

        // Randomised traffic on both instances under the requester contract.
        repeat (400) begin
            for (int u = 0; u < 2; u++) begin
                en_v[u] = ($urandom_range(0, 9) != 0);
                for (int i = 0; i < int'(N); i++) begin
                    if (o_gnt[u][i]) begin
                        req_v[u][i]  = ($urandom_range(0, 3) != 0);
                        data_v[u][i] = $urandom;
                    end else if (req_v[u][i]) begin
                        if ($urandom_range(0, 19) == 0) req_v[u][i] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        req_v[u][i]  = 1'b1;
                        data_v[u][i] = $urandom;
                    end
                end
            end
            tick();
        end

        // issued_cnt wrap: preload 16'hFFFF, then one launch.
        for (int u = 0; u < 2; u++) begin
            req_v[u] = '0;
            en_v[u]  = 1'b1;
        end
        repeat (8) tick();
        force dut0.issued_cnt_q = 16'hFFFF;
        m_iss[0] = 16'hFFFF;
        tick();
        release dut0.issued_cnt_q;
        tick();
        chk("preload_iss", 0, DW'(o_iss[0]), 32'h0000FFFF);
        req_v[0]     = 4'b0001;
        data_v[0][0] = 32'hA5A5_0001;
        tick();
        chk("wrap_iss", 0, DW'(o_iss[0]), 32'd0);
        req_v[0] = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
